// File: rtl/r5_pkg.sv
// Shared constants, read-FSM state encoding and the stride-5 lane address helper
// for the radix-5 gather block.
package r5_pkg;

   localparam int R5_DW    = 32;
   localparam int R5_FRAME = 25;
   localparam int R5_RADIX = 5;

   typedef enum logic {
      R_IDLE  = 1'b0,
      R_DRAIN = 1'b1
   } r5_rstate_e;

   // Lane k of tuple idx lives at entry idx + 5k of a 25-entry bank.
   function automatic logic [4:0] lane_addr(input logic [2:0] idx, input int k);
      return 5'(idx) + 5'(R5_RADIX * k);
   endfunction

endpackage

// File: rtl/r5_bank.sv
// 25-entry complex register file: one sample write port and one 5-lane
// stride-5 read port. Storage is not reset.
module r5_bank
   import r5_pkg::*;
#(
   parameter int DW = R5_DW
) (
   input  logic                             clk,
   input  logic                             we,
   input  logic [4:0]                       wr_addr,
   input  logic [DW-1:0]                    wr_re,
   input  logic [DW-1:0]                    wr_img,
   input  logic [2:0]                       rd_idx,
   output logic [R5_RADIX-1:0][DW-1:0]      rd_re,
   output logic [R5_RADIX-1:0][DW-1:0]      rd_img
);

   logic [DW-1:0] mem_re  [R5_FRAME];
   logic [DW-1:0] mem_img [R5_FRAME];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_re[wr_addr]  <= wr_re;
         mem_img[wr_addr] <= wr_img;
      end
   end

   always_comb begin
      rd_re  = '0;
      rd_img = '0;
      for (int k = 0; k < R5_RADIX; k++) begin
         rd_re[k]  = mem_re[lane_addr(rd_idx, k)];
         rd_img[k] = mem_img[lane_addr(rd_idx, k)];
      end
   end

endmodule

// File: rtl/r5_gather.sv
// Radix-5 gather: collects 25 serial complex samples and emits five stride-5 tuples.
// Define R5_GATHER_PINGPONG_EN for two banks (fill and drain overlap); default is one bank.
//
// state   | meaning
// R_IDLE  | no complete frame in the read bank, out_valid low
// R_DRAIN | presenting tuple rd_idx of the read bank
module r5_gather
   import r5_pkg::*;
#(
   parameter int DW = R5_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_img,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic [DW-1:0] out_re0,
   output logic [DW-1:0] out_re1,
   output logic [DW-1:0] out_re2,
   output logic [DW-1:0] out_re3,
   output logic [DW-1:0] out_re4,
   output logic [DW-1:0] out_img0,
   output logic [DW-1:0] out_img1,
   output logic [DW-1:0] out_img2,
   output logic [DW-1:0] out_img3,
   output logic [DW-1:0] out_img4
);

`ifdef R5_GATHER_PINGPONG_EN
   localparam int NB = 2;
`else
   localparam int NB = 1;
`endif

   logic [4:0]                   wr_cnt;
   logic [2:0]                   rd_idx;
   logic                         wr_bank;
   logic                         rd_bank;
   logic [NB-1:0]                full;
   logic [NB-1:0]                full_nxt;
   r5_rstate_e                   state;
   r5_rstate_e                   state_nxt;
   logic                         accept;
   logic                         wr_wrap;
   logic                         rd_fire;
   logic                         rd_done;
   logic [R5_RADIX-1:0][DW-1:0]  bank_re  [NB];
   logic [R5_RADIX-1:0][DW-1:0]  bank_img [NB];
   logic [R5_RADIX-1:0][DW-1:0]  lane_re;
   logic [R5_RADIX-1:0][DW-1:0]  lane_img;

   for (genvar b = 0; b < NB; b++) begin : g_bank
      r5_bank #(.DW(DW)) u_bank (
         .clk     (clk),
         .we      (accept && (wr_bank == 1'(b))),
         .wr_addr (wr_cnt),
         .wr_re   (in_re),
         .wr_img  (in_img),
         .rd_idx  (rd_idx),
         .rd_re   (bank_re[b]),
         .rd_img  (bank_img[b])
      );
   end

   // in_ready comes only from registered FULL, so a clear and a write never share a cycle.
   assign in_ready  = !full[wr_bank];
   assign accept    = in_valid && in_ready;
   assign wr_wrap   = accept && (wr_cnt == 5'(R5_FRAME - 1));
   assign out_valid = (state == R_DRAIN);
   assign out_last  = out_valid && (rd_idx == 3'(R5_RADIX - 1));
   assign rd_fire   = out_valid && out_ready;
   assign rd_done   = rd_fire && (rd_idx == 3'(R5_RADIX - 1));

   always_comb begin
      full_nxt = full;
      if (rd_done) full_nxt[rd_bank] = 1'b0;
      if (wr_wrap) full_nxt[wr_bank] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         R_IDLE:  if (full[rd_bank]) state_nxt = R_DRAIN;
         R_DRAIN: if (rd_done)       state_nxt = R_IDLE;
         default:                    state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt  <= '0;
         rd_idx  <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         full    <= '0;
         state   <= R_IDLE;
      end else begin
         state <= state_nxt;
         full  <= full_nxt;
         if (accept) wr_cnt <= wr_wrap ? 5'd0 : wr_cnt + 5'd1;
         if (rd_fire) rd_idx <= rd_done ? 3'd0 : rd_idx + 3'd1;
`ifdef R5_GATHER_PINGPONG_EN
         if (wr_wrap) wr_bank <= ~wr_bank;
         if (rd_done) rd_bank <= ~rd_bank;
`endif
      end
   end

   always_comb begin
      lane_re  = '0;
      lane_img = '0;
      if (out_valid) begin
         lane_re  = bank_re[rd_bank];
         lane_img = bank_img[rd_bank];
      end
   end

   assign out_re0  = lane_re[0];
   assign out_re1  = lane_re[1];
   assign out_re2  = lane_re[2];
   assign out_re3  = lane_re[3];
   assign out_re4  = lane_re[4];
   assign out_img0 = lane_img[0];
   assign out_img1 = lane_img[1];
   assign out_img2 = lane_img[2];
   assign out_img3 = lane_img[3];
   assign out_img4 = lane_img[4];

endmodule

// File: tb/tb_r5_gather.sv
// Directed bench for r5_gather with a stride-5 reorder scoreboard; builds with or
// without R5_GATHER_PINGPONG_EN.
module tb_r5_gather;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_re = '0;
   logic [DW-1:0] in_img = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic [DW-1:0] out_re0, out_re1, out_re2, out_re3, out_re4;
   logic [DW-1:0] out_img0, out_img1, out_img2, out_img3, out_img4;

   r5_gather #(.DW(DW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_img(in_img),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .out_re0(out_re0), .out_re1(out_re1), .out_re2(out_re2), .out_re3(out_re3), .out_re4(out_re4),
      .out_img0(out_img0), .out_img1(out_img1), .out_img2(out_img2), .out_img3(out_img3), .out_img4(out_img4)
   );

   always #5 clk = ~clk;

   typedef logic [4:0][DW-1:0] lanes_t;

   int            n_tests = 0;
   int            n_fail = 0;
   int            last_cnt = 0;
   int            fcnt = 0;
   int            sent = 0;
   int            total = 0;
   logic [DW-1:0] base = '0;
   logic [DW-1:0] fr_re [25];
   logic [DW-1:0] fr_img [25];
   lanes_t        exp_re_q [$];
   lanes_t        exp_img_q [$];
   bit            exp_last_q [$];
   lanes_t        cur_re, cur_img, hold_re, hold_img, t_re, t_img;
   bit            hold_v = 1'b0;
   bit            lh = 1'b0;
   bit            e_last;

   assign cur_re  = {out_re4, out_re3, out_re2, out_re1, out_re0};
   assign cur_img = {out_img4, out_img3, out_img2, out_img1, out_img0};

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard and protocol monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         fcnt = 0;
         exp_re_q.delete();
         exp_img_q.delete();
         exp_last_q.delete();
         hold_v = 1'b0;
         lh = 1'b0;
      end else begin
         if (lh) chk("rdy_after_last", in_ready, 1);
         lh = out_valid && out_ready && out_last;
         if (hold_v) begin
            chk("stall_valid", out_valid, 1);
            for (int k = 0; k < 5; k++) begin
               chk("stall_re", cur_re[k], hold_re[k]);
               chk("stall_img", cur_img[k], hold_img[k]);
            end
         end
         hold_v   = out_valid && !out_ready;
         hold_re  = cur_re;
         hold_img = cur_img;
         if (!out_valid) begin
            for (int k = 0; k < 5; k++) begin
               chk("idle_re", cur_re[k], 0);
               chk("idle_img", cur_img[k], 0);
            end
            chk("idle_last", out_last, 0);
         end
`ifndef R5_GATHER_PINGPONG_EN
         if (out_valid) chk("drain_rdy", in_ready, 0);
`endif
         if (out_valid && out_ready) begin
            if (exp_re_q.size() == 0) begin
               chk("sb_underflow", 32'(exp_re_q.size()), 1);
            end else begin
               t_re   = exp_re_q.pop_front();
               t_img  = exp_img_q.pop_front();
               e_last = exp_last_q.pop_front();
               for (int k = 0; k < 5; k++) begin
                  chk("sb_re", cur_re[k], t_re[k]);
                  chk("sb_img", cur_img[k], t_img[k]);
               end
               chk("sb_last", out_last, e_last);
            end
            if (out_last) last_cnt++;
         end
         if (in_valid && in_ready) begin
            fr_re[fcnt]  = in_re;
            fr_img[fcnt] = in_img;
            fcnt++;
            if (fcnt == 25) begin
               for (int n = 0; n < 5; n++) begin
                  for (int k = 0; k < 5; k++) begin
                     t_re[k]  = fr_re[n + 5 * k];
                     t_img[k] = fr_img[n + 5 * k];
                  end
                  exp_re_q.push_back(t_re);
                  exp_img_q.push_back(t_img);
                  exp_last_q.push_back(n == 4);
               end
               fcnt = 0;
            end
         end
      end
   end

   task automatic step(input int vpct, input int rpct);
      in_valid  = (sent < total) && (int'($urandom_range(99)) < vpct);
      in_re     = base + DW'(sent);
      in_img    = base + DW'(sent) + 100;
      out_ready = (int'($urandom_range(99)) < rpct);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
   endtask

   task automatic finish_all(input int vpct, input int rpct, input int budget);
      int cyc = 0;
      while (!(sent == total && fcnt == 0 && exp_re_q.size() == 0 && !out_valid) && cyc < budget) begin
         step(vpct, rpct);
         cyc++;
      end
      chk("drain_budget", 32'(cyc < budget), 1);
   endtask

   initial begin
      int w;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_last", out_last, 0);
      chk("rst_re0", out_re0, 0);
      chk("rst_img4", out_img4, 0);
      @(posedge clk);
      #1;

      // Single frame 0..24, hand-checked tuples and 1-cycle latency.
      out_ready = 1'b1;
      for (int i = 0; i < 25; i++) begin
         in_valid = 1'b1;
         in_re    = DW'(i);
         in_img   = DW'(100 + i);
         @(negedge clk);
         chk("fill_rdy", in_ready, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_pre", out_valid, 0);
`ifdef R5_GATHER_PINGPONG_EN
      chk("full_rdy", in_ready, 1);
`else
      chk("full_rdy", in_ready, 0);
`endif
      @(posedge clk);
      #1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("d_valid", out_valid, 1);
         for (int k = 0; k < 5; k++) begin
            chk("d_re", cur_re[k], DW'(n + 5 * k));
            chk("d_img", cur_img[k], DW'(100 + n + 5 * k));
         end
         chk("d_last", out_last, DW'(n == 4));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("d_done", out_valid, 0);
      @(posedge clk);
      #1;

      // Reset after sample 12, then a fresh frame.
      for (int i = 0; i < 13; i++) begin
         in_valid = 1'b1;
         in_re    = DW'(i);
         in_img   = DW'(100 + i);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstm_valid", out_valid, 0);
      chk("rstm_rdy", in_ready, 1);
      @(posedge clk);
      #1;
      base = '0;
      sent = 0;
      total = 25;
      repeat (25) step(100, 0);
      in_valid = 1'b0;
      w = 0;
      @(negedge clk);
      while (!out_valid && w < 4) begin
         @(negedge clk);
         w++;
      end
      chk("rstm_wait", 32'(w < 4), 1);
      for (int k = 0; k < 5; k++) begin
         chk("rstm_re", cur_re[k], DW'(5 * k));
         chk("rstm_img", cur_img[k], DW'(100 + 5 * k));
      end
      @(posedge clk);
      #1;
      finish_all(100, 100, 200);

      // Downstream stalled 40 cycles while the next frame streams in.
      base = 200;
      sent = 0;
      total = 25;
      repeat (25) step(100, 0);
      total = 50;
      repeat (40) step(100, 0);
      total = 75;
      in_valid  = 1'b1;
      in_re     = base + DW'(sent);
      in_img    = base + DW'(sent) + 100;
      out_ready = 1'b0;
      @(negedge clk);
      chk("stall_inrdy", in_ready, 0);
      chk("stall_valid0", out_valid, 1);
      for (int k = 0; k < 5; k++) chk("stall_lane", cur_re[k], DW'(200 + 5 * k));
`ifdef R5_GATHER_PINGPONG_EN
      chk("stall_b_filled", sent, 50);
`else
      chk("stall_b_blocked", sent, 25);
`endif
      @(posedge clk);
      #1;
      finish_all(100, 100, 400);

      // Three back-to-back frames.
      base = 1000;
      sent = 0;
      total = 75;
      repeat (75) step(100, 100);
`ifdef R5_GATHER_PINGPONG_EN
      chk("b2b_sent", sent, 75);
`endif
      finish_all(100, 100, 400);

      // 100 frames with random handshakes.
      last_cnt = 0;
      base = 32'h0001_0000;
      sent = 0;
      total = 2500;
      finish_all(60, 60, 40000);
      chk("rand_last_cnt", last_cnt, 100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
